song_sequencer: RTL

Schedules auto-play for the piano datapath. Steps through a per-song note ROM and times each entry's duration with a tick counter. Inserts a silent gap between notes and drives the shared note, LED, octave and progress outputs that the top-level mode mux routes to the buzzer, LEDs and 7-segment display. Supports start, pause and stop control from the top level.

---
 rtl/song_sequencer_pkg.sv | 38 +++
 rtl/song_sequencer_if.sv | 27 ++
 rtl/song_sequencer_note_timer.sv | 26 ++
 rtl/song_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - shared states, note codes, ROM field offsets and helpers
package song_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    localparam logic [3:0] NOTE_REST     = 4'h0;
    localparam logic [3:0] NOTE_END      = 4'hF;
    localparam logic [3:0] NOTE_MAX_TONE = 4'd7;

    localparam int FLD_NOTE_LSB = 0;
    localparam int FLD_OCT_LSB  = 4;
    localparam int FLD_DUR_LSB  = 6;

    localparam logic [2:0] MODE_FREE  = 3'b100;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b001;

    // Wide enough for the longest note and for the inter-note gap.
    function automatic int cnt_width(input int tpu, input int gap);
        int longest;
        longest = 15 * tpu;
        if (gap > longest) longest = gap;
        return $clog2(longest + 1);
    endfunction

    function automatic logic [6:0] note_led(input logic [3:0] note);
        note_led = 7'd0;
        if (note >= 4'd1 && note <= NOTE_MAX_TONE) note_led = 7'd1 << (note - 4'd1);
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control, ROM and display signals of the song sequencer
interface song_sequencer_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             pause;
    logic             stop;
    logic [1:0]       song_select;
    logic [IDX_W+1:0] rom_addr;
    logic [11:0]      rom_data;
    logic [3:0]       note_out;
    logic [1:0]       octave_out;
    logic [6:0]       led_out;
    logic [3:0]       num;
    logic             busy;
    logic             done;

    modport master (
        output start, pause, stop, song_select, rom_data,
        input  rom_addr, note_out, octave_out, led_out, num, busy, done
    );

    modport slave (
        input  start, pause, stop, song_select, rom_data,
        output rom_addr, note_out, octave_out, led_out, num, busy, done
    );
endinterface

// File: rtl/song_sequencer_note_timer.sv
// rtl/song_sequencer_note_timer.sv - loadable down-counter timing notes and gaps
module song_sequencer_note_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expired
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Flags the last enabled cycle so a load of N spans exactly N enabled cycles.
    assign o_expired = i_enable && (r_count <= CNT_W'(1));
endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - auto-play sequencer stepping a song ROM with timed notes and gaps
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 12_500_000,
    parameter int GAP_TICKS      = 1_000_000,
    parameter int IDX_W          = 6
) (
    input  logic           clk,
    input  logic           reset,
    song_sequencer_if.slave bus
);
    localparam int              CNT_W    = cnt_width(TICKS_PER_UNIT, GAP_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [1:0]       r_song;
    logic [IDX_W-1:0] r_index;
    logic [3:0]       r_note;
    logic [1:0]       r_octave;
    logic [3:0]       r_num;

    logic [3:0]       w_rom_note;
    logic [1:0]       w_rom_oct;
    logic [3:0]       w_rom_dur;
    logic [3:0]       w_dur;
    logic [3:0]       w_note;
    logic [CNT_W-1:0] w_play_ticks;
    logic [CNT_W-1:0] w_timer_value;
    logic             w_timer_load;
    logic             w_timer_en;
    logic             w_expired;
    logic             w_unused_rsvd;

    assign w_rom_note    = bus.rom_data[FLD_NOTE_LSB +: 4];
    assign w_rom_oct     = bus.rom_data[FLD_OCT_LSB +: 2];
    assign w_rom_dur     = bus.rom_data[FLD_DUR_LSB +: 4];
    assign w_unused_rsvd = ^bus.rom_data[11:10];
    assign w_dur         = (w_rom_dur == 4'd0) ? 4'd1 : w_rom_dur;
    assign w_play_ticks  = CNT_W'(w_dur) * CNT_W'(TICKS_PER_UNIT);
    assign w_timer_en    = !bus.pause && (r_state == ST_PLAY || r_state == ST_GAP);

    song_sequencer_note_timer #(.CNT_W(CNT_W)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .i_enable     (w_timer_en),
        .o_expired    (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = '0;
        unique case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (w_rom_note == NOTE_END) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next  = ST_PLAY;
                    w_timer_load  = 1'b1;
                    w_timer_value = w_play_ticks;
                end
            end
            ST_PLAY: begin
                if (w_expired) begin
                    w_state_next  = ST_GAP;
                    w_timer_load  = 1'b1;
                    w_timer_value = CNT_W'(GAP_TICKS);
                end
            end
            ST_GAP:   if (w_expired) w_state_next = (r_index == IDX_LAST) ? ST_DONE : ST_FETCH;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        // stop outranks pause and expiry, so it overrides whatever was chosen above
        if (bus.stop && r_state != ST_IDLE) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_song   <= 2'd0;
            r_index  <= '0;
            r_note   <= NOTE_REST;
            r_octave <= 2'd0;
            r_num    <= 4'd0;
        end else begin
            if (r_state == ST_IDLE && w_state_next == ST_FETCH) begin
                r_song  <= bus.song_select;
                r_index <= '0;
                r_num   <= 4'd0;
            end
            if (r_state == ST_LOAD && w_state_next == ST_PLAY) begin
                r_note   <= (w_rom_note <= NOTE_MAX_TONE) ? w_rom_note : NOTE_REST;
                r_octave <= w_rom_oct;
            end
            if (r_state == ST_PLAY && w_state_next == ST_GAP && r_num != 4'd15) begin
                r_num <= r_num + 4'd1;
            end
            if (r_state == ST_GAP && w_state_next == ST_FETCH) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign w_note         = (r_state == ST_PLAY && !bus.pause) ? r_note : NOTE_REST;
    assign bus.note_out   = w_note;
    assign bus.led_out    = note_led(w_note);
    assign bus.octave_out = r_octave;
    assign bus.num        = r_num;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.rom_addr   = {r_song, r_index};
endmodule
